program_loader: RTL and testbench

Boot-time instruction writer for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes each word into the instruction memory's write port at consecutive word addresses, then verifies a trailing XOR checksum. The processor is held in reset until a load completes successfully, which replaces the simulation-only memory preload with a synthesizable path.

---
 rtl/program_loader.sv | 89 ++++++++
 tb/tb_program_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader writing big-endian words to instruction memory with XOR checksum; ports: CLK/RST, Start/Word_Count request, Byte_In/Byte_Valid/Byte_Ready stream, Mem_WE/Mem_Addr/Mem_WData write port, CPU_RST_N/Busy/Done/Error status
module program_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   Word_Count,
  input  logic [7:0]            Byte_In,
  input  logic                  Byte_Valid,
  output logic                  Byte_Ready,
  output logic                  Mem_WE,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_WData,
  output logic                  CPU_RST_N,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;
  state_t                state;
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH:0]   cnt;
  logic [1:0]            bcnt;
  logic [7:0]            acc;
  logic [DATA_WIDTH-9:0] asm_q;
  logic                  xfer;
  logic                  too_big;
  logic                  match;
  assign xfer    = Byte_Valid & Byte_Ready;
  assign too_big = Word_Count[ADDR_WIDTH] & (|Word_Count[ADDR_WIDTH-1:0]);
  assign match   = Byte_In == acc;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      Byte_Ready <= 1'b0;
      Mem_WE     <= 1'b0;
      Mem_Addr   <= '0;
      Mem_WData  <= '0;
      CPU_RST_N  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      bcnt       <= '0;
      acc        <= '0;
      asm_q      <= '0;
    end else begin
      Mem_WE <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: if (Start) begin
          idx        <= '0;
          bcnt       <= '0;
          acc        <= '0;
          cnt        <= Word_Count;
          CPU_RST_N  <= 1'b0;
          Done       <= 1'b0;
          Error      <= too_big;
          Busy       <= !too_big;
          Byte_Ready <= !too_big;
          state      <= too_big ? ERROR : (Word_Count == '0 ? CHECK : LOAD);
        end
        LOAD: if (xfer) begin
          asm_q <= {asm_q[DATA_WIDTH-17:0], Byte_In};
          acc   <= acc ^ Byte_In;
          bcnt  <= bcnt + 1;
          if (bcnt == 2'd3) begin
            Mem_WE    <= 1'b1;
            Mem_WData <= {asm_q, Byte_In};
            Mem_Addr  <= idx[ADDR_WIDTH-1:0];
            idx       <= idx + 1;
            if (idx + 1 == cnt) state <= CHECK;
          end
        end
        CHECK: if (xfer) begin
          Byte_Ready <= 1'b0;
          Busy       <= 1'b0;
          Done       <= match;
          Error      <= !match;
          CPU_RST_N  <= match;
          state      <= match ? DONE : ERROR;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized scoreboard bench for program_loader
module tb_program_loader;
  logic       CLK = 0;
  logic       RST;
  logic       Start;
  logic [8:0] Word_Count;
  logic [7:0] Byte_In;
  logic       Byte_Valid;
  logic       Byte_Ready;
  logic       Mem_WE;
  logic [7:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic       CPU_RST_N;
  logic       Busy;
  logic       Done;
  logic       Error;

  program_loader dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Word_Count(Word_Count),
    .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .Mem_WE(Mem_WE), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .CPU_RST_N(CPU_RST_N), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 CLK = ~CLK;

  typedef struct {logic [7:0] a; logic [31:0] d;} wr_t;
  wr_t        exp_q[$];
  logic [7:0] stream[$];
  int         checks = 0;
  int         failures = 0;
  int         we_cnt = 0;
  int         last_addr = -1;
  int         gap_at = -1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (Mem_WE === 1'b1) begin
      we_cnt++;
      last_addr = int'(Mem_Addr);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", Mem_Addr, Mem_WData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {24'h0, Mem_Addr}, {24'h0, e.a});
        check("write_data", Mem_WData, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int  n = 0;
    bit  ok = 0;
    Byte_In = b;
    Byte_Valid = 1;
    while (!ok && n < 50) begin
      ok = Byte_Ready;
      tick();
      n++;
    end
    Byte_Valid = 0;
    if (!ok) check("byte_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input int wc);
    Start = 1;
    Word_Count = 9'(wc);
    tick();
    Start = 0;
  endtask

  // stall: 0 none, 1 idle cycle before every byte, 2 random idle cycles
  task automatic run_load(input int wc, input int stall, input logic [7:0] chk_byte);
    int x = 0;
    bit ok;
    for (int i = 0; i < wc && wc <= 256; i++) begin
      wr_t e;
      e.a = 8'(i);
      e.d = 32'((int'(stream[4*i]) << 24) + (int'(stream[4*i+1]) << 16) + (int'(stream[4*i+2]) << 8) + int'(stream[4*i+3]));
      exp_q.push_back(e);
    end
    foreach (stream[i]) x = x ^ int'(stream[i]);
    ok = (wc <= 256) && (int'(chk_byte) == x);
    pulse_start(wc);
    if (wc > 256) begin
      check("big_error", {31'h0, Error}, 32'd1);
      check("big_ready", {31'h0, Byte_Ready}, 32'd0);
      check("big_busy", {31'h0, Busy}, 32'd0);
      check("big_cpu_rst_n", {31'h0, CPU_RST_N}, 32'd0);
      return;
    end
    check("start_busy", {31'h0, Busy}, 32'd1);
    check("start_cpu_rst_n", {31'h0, CPU_RST_N}, 32'd0);
    for (int i = 0; i <= stream.size(); i++) begin
      if (i == gap_at) repeat (5) tick();
      if (stall == 1) tick();
      if (stall == 2) repeat ($urandom_range(0, 2)) tick();
      put_byte(i < stream.size() ? stream[i] : chk_byte);
    end
    check("end_done", {31'h0, Done}, {31'h0, ok});
    check("end_error", {31'h0, Error}, {31'h0, !ok});
    check("end_cpu_rst_n", {31'h0, CPU_RST_N}, {31'h0, ok});
    check("end_busy", {31'h0, Busy}, 32'd0);
    tick();
    tick();
    check("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic set_demo();
    stream = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1; Start = 0; Word_Count = 0; Byte_In = 8'hAA; Byte_Valid = 1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ready", {31'h0, Byte_Ready}, 32'd0);
      check("rst_we", {31'h0, Mem_WE}, 32'd0);
      check("rst_addr", {24'h0, Mem_Addr}, 32'd0);
      check("rst_wdata", Mem_WData, 32'd0);
      check("rst_cpu_rst_n", {31'h0, CPU_RST_N}, 32'd0);
      check("rst_busy", {31'h0, Busy}, 32'd0);
      check("rst_done", {31'h0, Done}, 32'd0);
      check("rst_error", {31'h0, Error}, 32'd0);
    end
    RST = 0; Byte_Valid = 0;
    tick();
    check("idle_ready", {31'h0, Byte_Ready}, 32'd0);

    set_demo();
    run_load(2, 0, 8'h03);
    run_load(2, 0, 8'h04);
    run_load(2, 0, 8'h03);

    we_cnt = 0;
    gap_at = 2;
    run_load(2, 1, 8'h03);
    gap_at = -1;
    check("stall_we_pulses", we_cnt, 32'd2);

    // reset after five bytes: only word 0 is written
    begin
      wr_t e;
      e.a = 8'h00;
      e.d = 32'h20080005;
      exp_q.push_back(e);
    end
    we_cnt = 0;
    pulse_start(2);
    for (int i = 0; i < 5; i++) put_byte(stream[i]);
    RST = 1;
    tick();
    RST = 0;
    check("midrst_busy", {31'h0, Busy}, 32'd0);
    check("midrst_ready", {31'h0, Byte_Ready}, 32'd0);
    check("midrst_we", {31'h0, Mem_WE}, 32'd0);
    repeat (4) tick();
    check("midrst_we_pulses", we_cnt, 32'd1);
    stream = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_load(1, 0, 8'h00);

    stream = {};
    run_load(0, 0, 8'h00);
    run_load(0, 0, 8'hFF);
    run_load(257, 0, 8'h00);
    run_load(511, 0, 8'h00);

    stream = {};
    for (int i = 0; i < 1024; i++) stream.push_back(8'($urandom));
    run_load(256, 0, 8'h00 ^ stream.xor());
    check("full_last_addr", last_addr, 32'd255);

    for (int t = 0; t < 8; t++) begin
      int wc;
      logic [7:0] x;
      wc = $urandom_range(1, 6);
      stream = {};
      for (int i = 0; i < 4 * wc; i++) stream.push_back(8'($urandom));
      x = stream.xor();
      if ($urandom_range(0, 1) == 1) x = x ^ 8'($urandom_range(1, 255));
      run_load(wc, $urandom_range(0, 2), x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
